// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite layer engine.
//   rgb_t            24-bit RGB colour (8 bits per channel, R in [23:16])
//   DEF_*            default parameter values for sprite_layer_engine
//   TRANSPARENT_IDX  colour index that never wins priority resolution
//   clog2()          ceiling log2, usable in parameter expressions
package sprite_pkg;

    typedef logic [23:0] rgb_t;

    localparam int DEF_NUM_SPRITES = 4;
    localparam int DEF_SPR_W       = 32;
    localparam int DEF_SPR_H       = 32;
    localparam int DEF_COLOR_BITS  = 3;
    localparam int DEF_NUM_FRAMES  = 2;
    localparam int DEF_ANIM_DIV    = 15;

    localparam int TRANSPARENT_IDX = 0;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_hit_addr.sv
// sprite_hit_addr: combinational window test and ROM address for one sprite.
//   pixelx, pixely : current pixel coordinate
//   posx, posy     : active top-left corner of the sprite
//   frame          : animation frame to read (already forced to 0 when the
//                    sprite's animation is disabled)
//   hit            : coordinate lies inside the SPR_W x SPR_H window
//   rom_addr       : frame*SPR_W*SPR_H + dy*SPR_W + dx, or 0 on a miss
module sprite_hit_addr
    import sprite_pkg::*;
#(
    parameter int SPR_W   = DEF_SPR_W,
    parameter int SPR_H   = DEF_SPR_H,
    parameter int ADDR_W  = 11,
    parameter int FRAME_W = 1
) (
    input  logic [9:0]         pixelx,
    input  logic [9:0]         pixely,
    input  logic [9:0]         posx,
    input  logic [9:0]         posy,
    input  logic [FRAME_W-1:0] frame,
    output logic               hit,
    output logic [ADDR_W-1:0]  rom_addr
);

    localparam logic [10:0]       W11        = 11'(SPR_W);
    localparam logic [10:0]       H11        = 11'(SPR_H);
    localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(SPR_W * SPR_H);
    localparam logic [ADDR_W-1:0] ROW_SIZE   = ADDR_W'(SPR_W);

    logic [10:0] x_end;
    logic [10:0] y_end;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic [ADDR_W-1:0] lin_addr;

    // Window ends are 11 bits wide so a sprite hanging off column/row 1023
    // clips instead of wrapping back to 0.
    assign x_end = {1'b0, posx} + W11;
    assign y_end = {1'b0, posy} + H11;

    assign hit = (pixelx >= posx) && ({1'b0, pixelx} < x_end) &&
                 (pixely >= posy) && ({1'b0, pixely} < y_end);

    assign dx = pixelx - posx;
    assign dy = pixely - posy;

    assign lin_addr = ADDR_W'(frame) * FRAME_SIZE
                    + ADDR_W'(dy) * ROW_SIZE
                    + ADDR_W'(dx);

    assign rom_addr = hit ? lin_addr : '0;

endmodule

// File: rtl/sprite_layer_engine.sv
// sprite_layer_engine: multi-sprite renderer with fixed priority (sprite 0
// highest), transparency on colour index 0 and a writable palette.
//   clk, rst            pixel clock, synchronous active-high reset
//   frame_start         once per frame; latches staged sprite state and
//                       advances the animation divider
//   pixelx, pixely      coordinate presented in cycle N
//   posx, posy, enable,
//   anim_en             staged per-sprite state (10 bits per coordinate)
//   rom_addr, rom_q     per-sprite external ROMs, 1-cycle read latency
//   pal_we/addr/data    palette write port
//   RGB, visible,
//   sprite_id           registered result for the pixel of cycle N, at N+2
module sprite_layer_engine
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = DEF_NUM_SPRITES,
    parameter int SPR_W       = DEF_SPR_W,
    parameter int SPR_H       = DEF_SPR_H,
    parameter int COLOR_BITS  = DEF_COLOR_BITS,
    parameter int NUM_FRAMES  = DEF_NUM_FRAMES,
    parameter int ANIM_DIV    = DEF_ANIM_DIV,
    localparam int ADDR_W     = clog2(NUM_FRAMES * SPR_W * SPR_H),
    localparam int ID_W       = (NUM_SPRITES > 1) ? clog2(NUM_SPRITES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic [9:0]                    pixelx,
    input  logic [9:0]                    pixely,
    input  logic [10*NUM_SPRITES-1:0]     posx,
    input  logic [10*NUM_SPRITES-1:0]     posy,
    input  logic [NUM_SPRITES-1:0]        enable,
    input  logic [NUM_SPRITES-1:0]        anim_en,
    output logic [ADDR_W*NUM_SPRITES-1:0] rom_addr,
    input  logic [COLOR_BITS*NUM_SPRITES-1:0] rom_q,
    input  logic                          pal_we,
    input  logic [COLOR_BITS-1:0]         pal_addr,
    input  logic [23:0]                   pal_data,
    output rgb_t                          RGB,
    output logic                          visible,
    output logic [ID_W-1:0]               sprite_id
);

    localparam int FRAME_W = (NUM_FRAMES > 1) ? clog2(NUM_FRAMES) : 1;
    localparam int DIV_W   = (ANIM_DIV > 1) ? clog2(ANIM_DIV) : 1;
    localparam int PAL_N   = 2 ** COLOR_BITS;

    // Active (shadowed) sprite state.
    logic [10*NUM_SPRITES-1:0] act_posx;
    logic [10*NUM_SPRITES-1:0] act_posy;
    logic [NUM_SPRITES-1:0]    act_enable;
    logic [NUM_SPRITES-1:0]    act_anim_en;

    logic [DIV_W-1:0]   div_cnt;
    logic [FRAME_W-1:0] anim_frame;

    logic [NUM_SPRITES-1:0] hit;
    logic [NUM_SPRITES-1:0] hit_q;

    rgb_t palette [PAL_N];

    logic                  found;
    logic [ID_W-1:0]       win_id;
    logic [COLOR_BITS-1:0] win_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            act_posx    <= '0;
            act_posy    <= '0;
            act_enable  <= '0;
            act_anim_en <= '0;
            div_cnt     <= '0;
            anim_frame  <= '0;
        end else if (frame_start) begin
            act_posx    <= posx;
            act_posy    <= posy;
            act_enable  <= enable;
            act_anim_en <= anim_en;
            if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
                div_cnt    <= '0;
                anim_frame <= (anim_frame == FRAME_W'(NUM_FRAMES - 1)) ?
                              '0 : anim_frame + FRAME_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
        logic [FRAME_W-1:0] frame_sel;
        assign frame_sel = act_anim_en[g] ? anim_frame : '0;

        sprite_hit_addr #(
            .SPR_W  (SPR_W),
            .SPR_H  (SPR_H),
            .ADDR_W (ADDR_W),
            .FRAME_W(FRAME_W)
        ) u_hit_addr (
            .pixelx  (pixelx),
            .pixely  (pixely),
            .posx    (act_posx[10*g +: 10]),
            .posy    (act_posy[10*g +: 10]),
            .frame   (frame_sel),
            .hit     (hit[g]),
            .rom_addr(rom_addr[ADDR_W*g +: ADDR_W])
        );
    end

    // Enable is folded in at stage 0 so a frame_start landing while a pixel
    // is in flight cannot change that pixel's outcome.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit & act_enable;
        end
    end

    // Scan from lowest priority up so the lowest index candidate wins.
    always_comb begin
        found   = 1'b0;
        win_id  = '0;
        win_idx = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_q[i] &&
                rom_q[i*COLOR_BITS +: COLOR_BITS] != COLOR_BITS'(TRANSPARENT_IDX)) begin
                found   = 1'b1;
                win_id  = ID_W'(i);
                win_idx = rom_q[i*COLOR_BITS +: COLOR_BITS];
            end
        end
    end

    // The read below samples palette before this edge's write lands, so a
    // same-cycle write to the entry being read yields the old colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < PAL_N; k++) begin
                palette[k] <= '0;
            end
        end else if (pal_we) begin
            palette[pal_addr] <= pal_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RGB       <= '0;
            visible   <= 1'b0;
            sprite_id <= '0;
        end else begin
            RGB       <= found ? palette[win_idx] : '0;
            visible   <= found;
            sprite_id <= win_id;
        end
    end

endmodule

// File: tb/tb_sprite_layer_engine.sv
// tb_sprite_layer_engine: scoreboard bench for sprite_layer_engine with
// default parameters (4 sprites, 32x32, 3-bit colour, 2 frames, ANIM_DIV 15).
module tb_sprite_layer_engine;

    localparam int NS = 4;
    localparam int CB = 3;
    localparam int AW = 11;

    localparam logic [26:0] NONE = 27'd0;
    localparam logic [26:0] V_RED = {1'b1, 2'd0, 24'hFF0000};

    // clock / reset / DUT signals
    logic            clk = 1'b0;
    logic            rst;
    logic            frame_start;
    logic [9:0]      pixelx;
    logic [9:0]      pixely;
    logic [10*NS-1:0] posx;
    logic [10*NS-1:0] posy;
    logic [NS-1:0]   enable;
    logic [NS-1:0]   anim_en;
    logic [AW*NS-1:0] rom_addr;
    logic [CB*NS-1:0] rom_q;
    logic            pal_we;
    logic [CB-1:0]   pal_addr;
    logic [23:0]     pal_data;
    logic [23:0]     rgb;
    logic            visible;
    logic [1:0]      sprite_id;

    always #5 clk = ~clk;

    sprite_layer_engine dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .pixelx     (pixelx),
        .pixely     (pixely),
        .posx       (posx),
        .posy       (posy),
        .enable     (enable),
        .anim_en    (anim_en),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .pal_we     (pal_we),
        .pal_addr   (pal_addr),
        .pal_data   (pal_data),
        .RGB        (rgb),
        .visible    (visible),
        .sprite_id  (sprite_id)
    );

    // External sprite ROMs: every word of ROM i holds rom_fill[i], read
    // through a 1-cycle output register.
    logic [CB-1:0] rom_fill [NS];
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            rom_q[i*CB +: CB] <= rom_fill[i];
        end
    end

    // scoreboard
    logic [26:0] exp_q [$];
    string       tag_q [$];
    logic        check_now;
    logic [1:0]  pipe;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          fs_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: compare the pixel presented two cycles back at the falling
    // edge, then return 1 time unit after the next rising edge.
    task automatic cyc();
        logic [26:0] e;
        string       t;
        @(negedge clk);
        if (pipe[1]) begin
            check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, 32'({visible, sprite_id, rgb}), 32'(e));
            end
        end
        pipe = {pipe[0], check_now};
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic pix(input int x, input int y, input logic [26:0] exp, input string tag);
        pixelx    = 10'(x);
        pixely    = 10'(y);
        check_now = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        cyc();
        check_now = 1'b0;
    endtask

    task automatic fs();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        fs_count++;
    endtask

    task automatic pal_wr(input int a, input logic [23:0] d);
        pal_we   = 1'b1;
        pal_addr = CB'(a);
        pal_data = d;
        cyc();
        pal_we   = 1'b0;
    endtask

    task automatic set_pos(input int i, input int x, input int y);
        posx[i*10 +: 10] = 10'(x);
        posy[i*10 +: 10] = 10'(y);
    endtask

    task automatic addr_chk(input int x, input int y, input int i, input int exp, input string tag);
        pixelx = 10'(x);
        pixely = 10'(y);
        #1;
        check(tag, 32'(rom_addr[i*AW +: AW]), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; pixelx = '0; pixely = '0;
        posx = '0; posy = '0; enable = '0; anim_en = '0;
        pal_we = 1'b0; pal_addr = '0; pal_data = '0;
        check_now = 1'b0; pipe = '0;
        for (int i = 0; i < NS; i++) rom_fill[i] = '0;

        cyc();
        check("reset_rgb", 32'(rgb), 32'd0);
        check("reset_visible", 32'(visible), 32'd0);
        check("reset_id", 32'(sprite_id), 32'd0);
        cyc();
        rst = 1'b0;

        pal_wr(1, 24'hFF0000);
        pal_wr(2, 24'h00FF00);
        pal_wr(3, 24'h0000FF);

        // clipping
        rom_fill[0] = 3'd1;
        set_pos(0, 100, 50);
        enable  = 4'b0001;
        anim_en = 4'b0001;
        fs();
        addr_chk(100, 50, 0, 0, "addr_origin");
        addr_chk(131, 81, 0, 1023, "addr_corner");
        addr_chk(132, 81, 0, 0, "addr_miss");
        pix(100, 50, V_RED, "clip_origin");
        pix(99, 50, NONE, "clip_left");
        pix(132, 50, NONE, "clip_right");
        pix(131, 81, V_RED, "clip_corner");
        pix(131, 82, NONE, "clip_below");
        idle(3);

        // priority and transparency; sprite 2 is opaque but disabled
        set_pos(0, 200, 200);
        set_pos(1, 200, 200);
        set_pos(2, 200, 200);
        enable = 4'b0011;
        rom_fill[0] = 3'd2; rom_fill[1] = 3'd3; rom_fill[2] = 3'd1;
        fs();
        pix(200, 200, {1'b1, 2'd0, 24'h00FF00}, "prio_s0");
        rom_fill[0] = 3'd0;
        pix(200, 200, {1'b1, 2'd1, 24'h0000FF}, "prio_s1");
        rom_fill[1] = 3'd0;
        pix(200, 200, NONE, "prio_none");
        idle(3);

        // shadowing
        rom_fill[0] = 3'd1; rom_fill[1] = 3'd0; rom_fill[2] = 3'd0;
        set_pos(0, 100, 50);
        enable = 4'b0001;
        fs();
        pix(100, 50, V_RED, "shadow_old_a");
        set_pos(0, 300, 50);
        pix(100, 50, V_RED, "shadow_old_b");
        pix(300, 50, NONE, "shadow_new_early");
        fs();
        pix(300, 50, V_RED, "shadow_new");
        pix(100, 50, NONE, "shadow_old_gone");
        idle(3);

        // right-edge clip without wrap
        set_pos(0, 1010, 50);
        fs();
        pix(1023, 50, V_RED, "edge_hit");
        pix(0, 50, NONE, "edge_nowrap");
        pix(1010, 50, V_RED, "edge_left");
        idle(3);
        addr_chk(1023, 50, 0, 13, "edge_addr");

        // animation: sprite 0 animated, sprite 1 not
        set_pos(0, 100, 50);
        set_pos(1, 100, 50);
        anim_en = 4'b0001;
        while (fs_count < 14) fs();
        addr_chk(100, 50, 0, 0, "anim_before");
        fs();
        addr_chk(100, 50, 0, 1024, "anim_frame1");
        addr_chk(131, 81, 0, 2047, "anim_frame1_end");
        addr_chk(100, 50, 1, 0, "anim_off");
        pix(100, 50, V_RED, "anim_pixel");
        idle(3);
        while (fs_count < 30) fs();
        addr_chk(100, 50, 0, 0, "anim_wrap");

        // palette read/write hazard on index 3
        rom_fill[0] = 3'd3;
        pix(100, 50, {1'b1, 2'd0, 24'h0000FF}, "hazard_old");
        pal_we = 1'b1; pal_addr = 3'd3; pal_data = 24'h123456;
        pix(101, 50, {1'b1, 2'd0, 24'h123456}, "hazard_new");
        pal_we = 1'b0;
        idle(3);

        // mid-line reset; frame_start and pal_we alongside it are ignored
        pixelx = 10'd100; pixely = 10'd50;
        idle(2);
        check("pre_rst_visible", 32'(visible), 32'd1);
        rst = 1'b1; frame_start = 1'b1;
        pal_we = 1'b1; pal_addr = 3'd3; pal_data = 24'hABCDEF;
        cyc();
        check("rst_mid_visible", 32'(visible), 32'd0);
        check("rst_mid_rgb", 32'(rgb), 32'd0);
        check("rst_mid_id", 32'(sprite_id), 32'd0);
        rst = 1'b0; frame_start = 1'b0; pal_we = 1'b0;
        cyc();
        check("post_rst_visible_a", 32'(visible), 32'd0);
        cyc();
        check("post_rst_visible_b", 32'(visible), 32'd0);
        fs();
        pix(100, 50, {1'b1, 2'd0, 24'h000000}, "rst_pal_cleared");
        idle(3);

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
